// File: rtl/imm_pack.sv
// imm_pack: scatters a 32-bit immediate into the RV32I I/S/B/J fields of a base word.
// The registered output is backed by a single skid entry. Immediates that the extender cannot reproduce are flagged.
module imm_pack #(
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       immsrc,
    input  logic [31:0]      base,
    input  logic [31:0]      imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      instr,
    output logic             out_err,
    input  logic             err_clr,
    output logic [ERR_W-1:0] err_cnt
);

    localparam logic [1:0] SRC_I = 2'b00;
    localparam logic [1:0] SRC_S = 2'b01;
    localparam logic [1:0] SRC_B = 2'b10;
    localparam logic [1:0] SRC_J = 2'b11;

    localparam logic [ERR_W-1:0] CNT_MAX = '1;
    localparam logic [ERR_W-1:0] CNT_ONE = {{(ERR_W-1){1'b0}}, 1'b1};

    // Handshake: a transfer happens on a rising edge where valid & ready are both high.
    // Once valid is raised, the producer holds it and the payload until that edge.
    // in_ready depends only on registered state, never on out_ready in the same cycle.

    logic [31:0]      w_packed;
    logic             w_err;
    logic             w_accept;
    logic             w_load;
    logic             w_hi_i;
    logic             w_hi_b;
    logic             w_hi_j;

    logic             r_out_valid;
    logic [31:0]      r_instr;
    logic             r_out_err;
    logic             r_skid_valid;
    logic [31:0]      r_skid_instr;
    logic             r_skid_err;
    logic [ERR_W-1:0] r_err_cnt;

    always_comb begin
        w_packed = base;
        case (immsrc)
            SRC_S: begin
                w_packed[31:25] = imm[11:5];
                w_packed[11:7]  = imm[4:0];
            end
            SRC_B: begin
                w_packed[31]    = imm[12];
                w_packed[7]     = imm[11];
                w_packed[30:25] = imm[10:5];
                w_packed[11:8]  = imm[4:1];
            end
            SRC_J: begin
                w_packed[31]    = imm[20];
                w_packed[30:21] = imm[10:1];
                w_packed[20]    = imm[11];
                w_packed[19:12] = imm[19:12];
            end
            default: begin
                w_packed[31:20] = imm[11:0];
            end
        endcase
    end

    // An immediate survives the extender only if every bit above the top field bit equals the sign.
    assign w_hi_i = (&imm[31:11]) | ~(|imm[31:11]);
    assign w_hi_b = (&imm[31:12]) | ~(|imm[31:12]);
    assign w_hi_j = (&imm[31:20]) | ~(|imm[31:20]);

    always_comb begin
        w_err = 1'b0;
        case (immsrc)
            SRC_I:   w_err = ~w_hi_i;
            SRC_S:   w_err = ~w_hi_i;
            SRC_B:   w_err = ~w_hi_b | imm[0];
            default: w_err = ~w_hi_j | imm[0];
        endcase
    end

    assign in_ready = ~r_skid_valid;
    assign w_accept = in_valid & ~r_skid_valid;
    assign w_load   = ~r_out_valid | out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid  <= 1'b0;
            r_instr      <= '0;
            r_out_err    <= 1'b0;
            r_skid_valid <= 1'b0;
            r_skid_instr <= '0;
            r_skid_err   <= 1'b0;
        end else if (w_load) begin
            if (r_skid_valid) begin
                r_out_valid  <= 1'b1;
                r_instr      <= r_skid_instr;
                r_out_err    <= r_skid_err;
                r_skid_valid <= 1'b0;
            end else if (w_accept) begin
                r_out_valid <= 1'b1;
                r_instr     <= w_packed;
                r_out_err   <= w_err;
            end else begin
                r_out_valid <= 1'b0;
            end
        end else if (w_accept) begin
            // Output is stalled: park the new word behind it.
            r_skid_valid <= 1'b1;
            r_skid_instr <= w_packed;
            r_skid_err   <= w_err;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_err_cnt <= '0;
        end else if (err_clr) begin
            r_err_cnt <= (w_accept & w_err) ? CNT_ONE : '0;
        end else if (w_accept & w_err & (r_err_cnt != CNT_MAX)) begin
            r_err_cnt <= r_err_cnt + CNT_ONE;
        end
    end

    assign out_valid = r_out_valid;
    assign instr     = r_instr;
    assign out_err   = r_out_err;
    assign err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_imm_pack.sv
// Bench for imm_pack: directed vectors, error counter, backpressure, random streams and reset.
// The reference model packs by bit map, range-checks arithmetically, and re-extends for round trips.
module tb_imm_pack;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  immsrc;
    logic [31:0] base;
    logic [31:0] imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] instr;
    logic        out_err;
    logic        err_clr;
    logic [7:0]  err_cnt;

    always #5 clk = ~clk;

    imm_pack #(.ERR_W(8)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .immsrc(immsrc), .base(base), .imm(imm),
        .out_valid(out_valid), .out_ready(out_ready),
        .instr(instr), .out_err(out_err),
        .err_clr(err_clr), .err_cnt(err_cnt)
    );

    int          n_checks = 0;
    int          n_pass   = 0;
    int          n_acc    = 0;
    int          model_cnt = 0;
    logic [66:0] exp_q[$];          // {err, immsrc, imm, instr}
    logic        hold_v = 1'b0;
    logic [32:0] held;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // Which immediate bit lands in instruction bit b, or -1 if b keeps the base bit.
    function automatic int src_bit(input logic [1:0] f, input int b);
        case (f)
            2'd0: return (b >= 20) ? b - 20 : -1;
            2'd1: begin
                if (b >= 25) return b - 20;
                if (b >= 7 && b <= 11) return b - 7;
                return -1;
            end
            2'd2: begin
                if (b == 31) return 12;
                if (b == 7) return 11;
                if (b >= 25) return b - 20;
                if (b >= 8 && b <= 11) return b - 7;
                return -1;
            end
            default: begin
                if (b == 31) return 20;
                if (b >= 21) return b - 20;
                if (b == 20) return 11;
                if (b >= 12) return b;
                return -1;
            end
        endcase
    endfunction

    function automatic logic [31:0] model_pack(input logic [1:0] f, input logic [31:0] bw,
                                               input logic [31:0] iv);
        logic [31:0] r;
        int s;
        r = bw;
        for (int b = 0; b < 32; b++) begin
            s = src_bit(f, b);
            if (s >= 0) r[b] = iv[s];
        end
        return r;
    endfunction

    function automatic logic model_err(input logic [1:0] f, input logic [31:0] iv);
        longint v;
        v = longint'($signed(iv));
        case (f)
            2'd0, 2'd1: return (v < -2048) || (v > 2047);
            2'd2:       return (v < -4096) || (v > 4095) || iv[0];
            default:    return (v < -(64'sd1 << 20)) || (v > (64'sd1 << 20) - 1) || iv[0];
        endcase
    endfunction

    function automatic logic [31:0] extend(input logic [31:0] w, input logic [1:0] f);
        int v;
        case (f)
            2'd0: v = int'($signed(w) >>> 20);
            2'd1: v = int'($signed(w) >>> 25) * 32 + int'(w[11:7]);
            2'd2: v = int'($signed(w) >>> 31) * 4096 + int'(w[7]) * 2048
                      + int'(w[30:25]) * 32 + int'(w[11:8]) * 2;
            default: v = int'($signed(w) >>> 31) * (1 << 20) + int'(w[19:12]) * 4096
                         + int'(w[20]) * 2048 + int'(w[30:21]) * 2;
        endcase
        return v;
    endfunction

    function automatic logic [31:0] rand_imm_ok(input logic [1:0] f);
        int v;
        case (f)
            2'd0, 2'd1: v = int'($urandom_range(0, 4095)) - 2048;
            2'd2:       v = (int'($urandom_range(0, 4095)) - 2048) * 2;
            default:    v = (int'($urandom_range(0, 1048575)) - 524288) * 2;
        endcase
        return v;
    endfunction

    // Bookkeeping for the upcoming rising edge, then advance to the next falling edge.
    task automatic tick();
        logic [66:0] e;
        logic        er;
        if (reset) begin
            exp_q.delete();
            model_cnt = 0;
            hold_v = 1'b0;
        end else begin
            chk("err_cnt", {24'b0, err_cnt}, model_cnt);
            if (hold_v) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_instr", instr, held[31:0]);
                chk("hold_err", out_err, held[32]);
            end
            hold_v = out_valid && !out_ready;
            held   = {out_err, instr};
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_out", out_valid, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("instr", instr, e[31:0]);
                    chk("out_err", out_err, e[66]);
                    if (!e[66]) chk("round_trip", extend(instr, e[65:64]), e[63:32]);
                end
            end
            if (in_valid && in_ready) begin
                er = model_err(immsrc, imm);
                exp_q.push_back({er, immsrc, imm, model_pack(immsrc, base, imm)});
                n_acc++;
                if (err_clr) model_cnt = er ? 1 : 0;
                else if (er && model_cnt < 255) model_cnt++;
            end else if (err_clr) begin
                model_cnt = 0;
            end
        end
        @(negedge clk);
    endtask

    task automatic send(input logic [1:0] f, input logic [31:0] bw, input logic [31:0] iv);
        int k;
        in_valid = 1'b1; immsrc = f; base = bw; imm = iv;
        k = 0;
        while (!in_ready && k < 100) begin
            tick();
            k++;
        end
        if (k >= 100) chk("accept_timeout", in_ready, 1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic directed(input string tag, input logic [1:0] f, input logic [31:0] bw,
                            input logic [31:0] iv, input logic [31:0] ei, input logic ee);
        out_ready = 1'b1;
        send(f, bw, iv);
        chk({tag, "_valid"}, out_valid, 1);
        chk({tag, "_instr"}, instr, ei);
        chk({tag, "_err"}, out_err, ee);
        tick();
    endtask

    task automatic drain();
        int k;
        in_valid = 1'b0; out_ready = 1'b1;
        k = 0;
        while ((out_valid || exp_q.size() != 0) && k < 50) begin
            tick();
            k++;
        end
        chk("drain_empty", exp_q.size(), 0);
    endtask

    initial begin
        int a0, idx, sent, cyc;
        logic [31:0] snap;
        logic [31:0] bp_base[3];
        logic [31:0] bp_imm[3];

        reset = 1'b1; in_valid = 1'b0; immsrc = 2'd0; base = '0; imm = '0;
        out_ready = 1'b0; err_clr = 1'b0;
        @(negedge clk);
        tick();
        reset = 1'b0;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_instr", instr, 0);
        chk("rst_err_cnt", {24'b0, err_cnt}, 0);

        // Reference vectors.
        directed("t1_i", 2'd0, 32'h0000_0013, 32'hFFFF_FFFF, 32'hFFF0_0013, 1'b0);
        directed("t2_s", 2'd1, 32'h0000_2023, 32'h0000_07FC, 32'h7E00_2E23, 1'b0);
        directed("t2_b", 2'd2, 32'h0000_0063, 32'hFFFF_FFFC, 32'hFE00_0EE3, 1'b0);
        directed("t2_j", 2'd3, 32'h0000_006F, 32'h0000_0008, 32'h0080_006F, 1'b0);

        // Error flagging and counter.
        directed("t3_i", 2'd0, 32'h0000_0013, 32'h0000_0800, 32'h8000_0013, 1'b1);
        directed("t3_b", 2'd2, 32'h0000_0063, 32'h0000_0005, 32'h0000_0263, 1'b1);
        chk("err_cnt_two", {24'b0, err_cnt}, 2);
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        chk("err_cnt_clr", {24'b0, err_cnt}, 0);
        err_clr = 1'b1;
        send(2'd0, 32'h13, 32'h0000_0800);
        err_clr = 1'b0;
        chk("err_cnt_clr_acc", {24'b0, err_cnt}, 1);
        out_ready = 1'b1; in_valid = 1'b1; immsrc = 2'd0; base = 32'h13;
        for (int i = 0; i < 300; i++) begin
            imm = 32'h0000_1000 + i;
            tick();
        end
        in_valid = 1'b0;
        tick();
        chk("err_cnt_sat", {24'b0, err_cnt}, 255);
        drain();
        err_clr = 1'b1; tick(); err_clr = 1'b0;

        // Backpressure: two slots, third request must wait.
        for (int i = 0; i < 3; i++) begin
            bp_base[i] = $urandom;
            bp_imm[i]  = rand_imm_ok(2'd1);
        end
        out_ready = 1'b0; a0 = n_acc; idx = 0;
        in_valid = 1'b1; immsrc = 2'd1;
        for (int i = 0; i < 4; i++) begin
            base = bp_base[idx]; imm = bp_imm[idx];
            cyc = n_acc;
            tick();
            if (n_acc > cyc && idx < 2) idx++;
        end
        chk("bp_accepted", n_acc - a0, 2);
        chk("bp_in_ready", in_ready, 0);
        snap = instr;
        tick(); tick();
        chk("bp_stall_instr", instr, snap);
        in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        drain();

        // Random in-range stream with random backpressure.
        sent = 0; cyc = 0; in_valid = 1'b0;
        while (sent < 1000 && cyc < 20000) begin
            if (!in_valid) begin
                immsrc = 2'($urandom_range(0, 3));
                base = $urandom;
                imm = rand_imm_ok(immsrc);
                in_valid = ($urandom_range(0, 3) != 0);
            end
            out_ready = ($urandom_range(0, 3) != 0);
            a0 = n_acc;
            tick();
            cyc++;
            if (n_acc > a0) begin
                sent++;
                in_valid = 1'b0;
            end
        end
        chk("rand_sent", sent, 1000);
        drain();

        // Mixed stream including out-of-range immediates.
        sent = 0; cyc = 0; in_valid = 1'b0;
        while (sent < 300 && cyc < 10000) begin
            if (!in_valid) begin
                immsrc = 2'($urandom_range(0, 3));
                base = $urandom;
                imm = $urandom_range(0, 1) ? $urandom : rand_imm_ok(immsrc);
                in_valid = ($urandom_range(0, 2) != 0);
            end
            out_ready = ($urandom_range(0, 2) != 0);
            err_clr = ($urandom_range(0, 40) == 0);
            a0 = n_acc;
            tick();
            cyc++;
            if (n_acc > a0) begin
                sent++;
                in_valid = 1'b0;
            end
        end
        err_clr = 1'b0;
        chk("mixed_sent", sent, 300);
        drain();

        // Reset with the skid entry occupied.
        out_ready = 1'b0; in_valid = 1'b1; immsrc = 2'd0; base = 32'h13; imm = 32'h0000_0800;
        cyc = 0;
        while (in_ready && cyc < 10) begin
            tick();
            cyc++;
        end
        chk("skid_full", in_ready, 0);
        reset = 1'b1;
        tick();
        chk("rst6_out_valid", out_valid, 0);
        chk("rst6_in_ready", in_ready, 1);
        chk("rst6_err_cnt", {24'b0, err_cnt}, 0);
        chk("rst6_instr", instr, 0);
        chk("rst6_out_err", out_err, 0);
        reset = 1'b0; in_valid = 1'b0;
        tick();
        directed("t6_j", 2'd3, 32'h0000_006F, 32'h0000_0008, 32'h0080_006F, 1'b0);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1);
    end

endmodule
